ntt_iter_engine: RTL and testbench

- Parametrised N-point cyclic NTT/INTT engine over Z_Q. It generalises the fixed 4-point pipeline to any power-of-two N and adds a selectable inverse mode with N^-1 scaling.
- Coefficients stream in serially over a valid/ready handshake and are stored in an internal N-word register array.
- The transform runs in place with one time-multiplexed radix-2 DIT butterfly; results stream out in natural order with backpressure.
- Sits between the coefficient loader and the pointwise-multiply stage of the polynomial multiplier.

---
 rtl/ntt_pkg.sv | 58 +++++
 rtl/ntt_butterfly.sv | 21 ++
 rtl/ntt_iter_engine.sv | 159 +++++++++++++++
 tb/tb_ntt_iter_engine.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared modular arithmetic, index helpers, twiddle generation and FSM encoding
// for the iterative NTT engine.
package ntt_pkg;

    localparam int DW = 64;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_SCALE   = 2'd2,
        ST_OUTPUT  = 2'd3
    } state_t;

    function automatic logic [DW-1:0] mod_red(input logic [DW-1:0] a, input logic [DW-1:0] q);
        return a % q;
    endfunction

    function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [DW-1:0] q);
        logic [DW-1:0] s;
        s = a + b;
        return (s >= q) ? s - q : s;
    endfunction

    function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [DW-1:0] q);
        return (a >= b) ? a - b : a + q - b;
    endfunction

    function automatic logic [DW-1:0] mod_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [DW-1:0] q);
        return (a * b) % q;
    endfunction

    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int lg);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < lg) r[i] = idx[lg-1-i];
        end
        return r;
    endfunction

    // root^idx mod q by square-and-multiply; evaluated at elaboration for the twiddle table
    function automatic logic [DW-1:0] tw_entry(input logic [DW-1:0] root, input int idx,
                                               input logic [DW-1:0] q);
        logic [DW-1:0] r;
        logic [DW-1:0] b;
        r = 1;
        b = root % q;
        for (int i = 0; i < 16; i++) begin
            if (idx[i]) r = mod_mul(r, b, q);
            b = mod_mul(b, b, q);
        end
        return r;
    endfunction

endpackage

// File: rtl/ntt_butterfly.sv
// Combinational radix-2 DIT butterfly over Z_Q: (u + v*t, u - v*t) mod Q.
module ntt_butterfly
    import ntt_pkg::*;
#(
    parameter int W = 17,
    parameter int Q = 7681
) (
    input  logic [W-1:0] i_u,
    input  logic [W-1:0] i_v,
    input  logic [W-1:0] i_t,
    output logic [W-1:0] o_sum,
    output logic [W-1:0] o_diff
);

    logic [DW-1:0] w_p;

    assign w_p    = mod_mul(DW'(i_v), DW'(i_t), DW'(Q));
    assign o_sum  = W'(mod_add(DW'(i_u), w_p, DW'(Q)));
    assign o_diff = W'(mod_sub(DW'(i_u), w_p, DW'(Q)));

endmodule

// File: rtl/ntt_iter_engine.sv
// N-point in-place NTT/INTT: serial bit-reversed load, one butterfly per cycle,
// optional N^-1 scaling, natural-order streaming output with backpressure.
module ntt_iter_engine
    import ntt_pkg::*;
#(
    parameter int N         = 8,
    parameter int W         = 17,
    parameter int Q         = 7681,
    parameter int OMEGA     = 1925,
    parameter int OMEGA_INV = 1213,
    parameter int N_INV     = 6721
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy
);

    localparam int LOGN = $clog2(N);
    localparam int TWB  = LOGN - 1;
    localparam logic [LOGN-1:0] CNT_MAX = LOGN'(N - 1);
    localparam logic [LOGN-1:0] BF_MAX  = LOGN'(N / 2 - 1);
    localparam logic [LOGN-1:0] STG_MAX = LOGN'(LOGN - 1);

    state_t          r_state;
    state_t          w_next;
    logic [LOGN-1:0] r_cnt;
    logic [LOGN-1:0] r_stage;
    logic            r_mode;
    logic [W-1:0]    r_mem [N];

    logic [W-1:0]    w_tw_fwd [N/2];
    logic [W-1:0]    w_tw_inv [N/2];

    genvar gi;
    generate
        for (gi = 0; gi < N / 2; gi++) begin : g_tw
            assign w_tw_fwd[gi] = W'(tw_entry(DW'(OMEGA), gi, DW'(Q)));
            assign w_tw_inv[gi] = W'(tw_entry(DW'(OMEGA_INV), gi, DW'(Q)));
        end
    endgenerate

    // Butterfly index b enumerates pairs: a = group*2h + (b mod h), partner a+h.
    logic [LOGN-1:0] w_hmask;
    logic [LOGN-1:0] w_a;
    logic [LOGN-1:0] w_b;
    logic [TWB-1:0]  w_tidx;
    logic [W-1:0]    w_t;
    logic [LOGN-1:0] w_load_addr;

    assign w_hmask     = (LOGN'(1) << r_stage) - LOGN'(1);
    assign w_a         = ((r_cnt >> r_stage) << (r_stage + LOGN'(1))) | (r_cnt & w_hmask);
    assign w_b         = w_a | (LOGN'(1) << r_stage);
    assign w_tidx      = TWB'((r_cnt & w_hmask) << (STG_MAX - r_stage));
    assign w_t         = r_mode ? w_tw_inv[w_tidx] : w_tw_fwd[w_tidx];
    assign w_load_addr = LOGN'(bitrev(32'(r_cnt), LOGN));

    // SCALE reuses the butterfly multiplier with u=0 and the sum output.
    logic         w_is_scale;
    logic [W-1:0] w_bu;
    logic [W-1:0] w_bv;
    logic [W-1:0] w_bt;
    logic [W-1:0] w_sum;
    logic [W-1:0] w_diff;

    assign w_is_scale = (r_state == ST_SCALE);
    assign w_bu       = w_is_scale ? '0 : r_mem[w_a];
    assign w_bv       = w_is_scale ? r_mem[r_cnt] : r_mem[w_b];
    assign w_bt       = w_is_scale ? W'(N_INV) : w_t;

    ntt_butterfly #(.W(W), .Q(Q)) u_bfly (
        .i_u   (w_bu),
        .i_v   (w_bv),
        .i_t   (w_bt),
        .o_sum (w_sum),
        .o_diff(w_diff)
    );

    // A beat moves on either side only when valid and ready are both high at the clock edge.
    logic w_in_fire;
    logic w_out_fire;
    logic w_last;
    logic w_step;

    assign in_ready   = reset && (r_state == ST_LOAD);
    assign out_valid  = reset && (r_state == ST_OUTPUT);
    assign busy       = reset && (r_state != ST_LOAD);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_last     = (r_cnt == ((r_state == ST_COMPUTE) ? BF_MAX : CNT_MAX));
    assign out_data   = out_valid ? r_mem[r_cnt] : '0;
    assign out_last   = out_valid && w_last;

    always_comb begin
        w_next = r_state;
        w_step = 1'b0;
        unique case (r_state)
            ST_LOAD: begin
                w_step = w_in_fire;
                if (w_in_fire && w_last) w_next = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                w_step = 1'b1;
                if (w_last && (r_stage == STG_MAX)) w_next = r_mode ? ST_SCALE : ST_OUTPUT;
            end
            ST_SCALE: begin
                w_step = 1'b1;
                if (w_last) w_next = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                w_step = w_out_fire;
                if (w_out_fire && w_last) w_next = ST_LOAD;
            end
            default: w_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_LOAD;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_stage <= '0;
            r_mode  <= 1'b0;
        end else begin
            if (w_in_fire && (r_cnt == '0)) r_mode <= in_mode;
            if (w_step) begin
                r_cnt <= w_last ? '0 : r_cnt + LOGN'(1);
                if ((r_state == ST_COMPUTE) && w_last)
                    r_stage <= (r_stage == STG_MAX) ? '0 : r_stage + LOGN'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        case (r_state)
            ST_LOAD: begin
                if (w_in_fire) r_mem[w_load_addr] <= W'(mod_red(DW'(in_data), DW'(Q)));
            end
            ST_COMPUTE: begin
                r_mem[w_a] <= w_sum;
                r_mem[w_b] <= w_diff;
            end
            ST_SCALE: r_mem[r_cnt] <= w_sum;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ntt_iter_engine.sv
// Bench for ntt_iter_engine: direct-DFT reference model, per-cycle output checker,
// directed frames, random round trips with backpressure, mid-frame reset, N=4 instance.
module tb_ntt_iter_engine;

    localparam int N  = 8;
    localparam int W  = 17;
    localparam int Q  = 7681;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, in_valid, in_ready, in_mode, out_valid, out_ready, out_last, busy;
    logic [W-1:0] in_data, out_data;
    logic         reset4, in_valid4, in_ready4, in_mode4, out_valid4, out_ready4, out_last4, busy4;
    logic [W-1:0] in_data4, out_data4;

    ntt_iter_engine #(.N(8), .W(17), .Q(7681), .OMEGA(1925), .OMEGA_INV(1213), .N_INV(6721)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    ntt_iter_engine #(.N(4), .W(17), .Q(7681), .OMEGA(3383), .OMEGA_INV(4298), .N_INV(5761)) u_dut4 (
        .clk(clk), .reset(reset4), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .in_mode(in_mode4), .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .out_last(out_last4), .busy(busy4)
    );

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    int lat_q[$];
    int cyc = 0, t_last = 0, cur_lat = 0, in_cnt = 0, out_cnt = 0;
    bit waiting = 0, phase = 0, rnd_ready = 0, prev_stall = 0;
    logic [W-1:0] prev_data;
    logic prev_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // ---- reference model: plain DFT sums, no butterflies ----
    function automatic longint powm(input longint b, input int e);
        longint r;
        r = 1;
        for (int i = 0; i < e; i++) r = (r * (b % Q)) % Q;
        return r;
    endfunction

    function automatic void dft(input int n, input longint w, input longint scale,
                                input int xs[$], output int ys[$]);
        longint acc;
        ys = {};
        for (int k = 0; k < n; k++) begin
            acc = 0;
            for (int j = 0; j < n; j++)
                acc = (acc + (longint'(xs[j]) % Q) * powm(w, (j * k) % n)) % Q;
            ys.push_back(int'((acc * scale) % Q));
        end
    endfunction

    // ---- output / handshake checker, sampled on the falling edge ----
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            exp_q.delete();
            waiting = 0; phase = 0; in_cnt = 0; out_cnt = 0; prev_stall = 0;
        end else begin
            check("busy", busy, phase);
            if (!phase) begin
                check("idle_out_valid", out_valid, 0);
                check("idle_in_ready", in_ready, 1);
            end
            if (out_valid) begin
                check("in_ready_in_output", in_ready, 0);
                if (waiting) begin
                    check("latency", cyc - t_last, cur_lat);
                    waiting = 0;
                end
                if (prev_stall) begin
                    check("stall_data", out_data, prev_data);
                    check("stall_last", out_last, prev_last);
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) fail_now("extra_output_beat");
                    else begin
                        check("out_data", out_data, exp_q.pop_front());
                        check("out_last", out_last, 64'(out_cnt == N - 1));
                    end
                    if (out_cnt == N - 1) begin
                        out_cnt = 0;
                        phase = 0;
                    end else out_cnt++;
                end
                prev_stall = !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
            end else prev_stall = 0;
            if (in_valid && in_ready) begin
                if (in_cnt == N - 1) begin
                    in_cnt = 0; t_last = cyc; waiting = 1; phase = 1;
                    cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : -1;
                end else in_cnt++;
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // ---- driver tasks ----
    task automatic send_frame(input bit mode, input int xs[$]);
        int ys[$];
        int guard;
        dft(N, mode ? 1213 : 1925, mode ? 6721 : 1, xs, ys);
        foreach (ys[i]) exp_q.push_back(W'(ys[i]));
        lat_q.push_back(mode ? 21 : 13);
        for (int j = 0; j < N; j++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = W'(xs[j]);
            in_mode  = (j == 0) ? mode : ~mode;
            guard = 0;
            @(negedge clk);
            while (!in_ready && guard < 2000) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 2000) fail_now("in_ready_timeout");
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = W'($urandom_range(0, 1000));
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || phase) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic check_list(input string name, input int act[$], input int req[$]);
        for (int i = 0; i < req.size(); i++) check(name, act[i], req[i]);
    endtask

    initial begin
        int x[$], xx[$], y[$], back[$];
        int lit_shift[$], lit_ones[$], lit_delta8[$], lit_n4[$], imp[$], shf[$], ones[$];
        int guard;
        reset = 0; in_valid = 0; in_data = 0; in_mode = 0;
        reset4 = 0; in_valid4 = 0; in_data4 = 0; in_mode4 = 0; out_ready4 = 1;

        imp        = '{1, 0, 0, 0, 0, 0, 0, 0};
        shf        = '{0, 1, 0, 0, 0, 0, 0, 0};
        ones       = '{1, 1, 1, 1, 1, 1, 1, 1};
        lit_delta8 = '{8, 0, 0, 0, 0, 0, 0, 0};
        lit_shift  = '{1, 1925, 3383, 6468, 7680, 5756, 4298, 1213};
        lit_n4     = '{10, 913, 7679, 6764};

        // pin the model to hand-computed values
        dft(8, 1925, 1, shf, y);        check_list("model_shift", y, lit_shift);
        dft(8, 1925, 1, ones, y);       check_list("model_ones", y, lit_delta8);
        dft(8, 1213, 6721, lit_delta8, y); check_list("model_inv", y, ones);
        xx = '{1, 2, 3, 4};
        dft(4, 3383, 1, xx, y);         check_list("model_n4", y, lit_n4);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        reset = 1;
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1);
        @(posedge clk);
        #1;

        send_frame(0, imp);        wait_drain();
        send_frame(0, shf);        wait_drain();
        send_frame(0, ones);       wait_drain();
        send_frame(1, lit_delta8); wait_drain();

        // inputs at or above Q are reduced on load
        x = {};
        for (int j = 0; j < N; j++) x.push_back(Q + 1000 * j + 7);
        send_frame(0, x);          wait_drain();

        rnd_ready = 1;
        for (int it = 0; it < 100; it++) begin
            x = {};
            for (int j = 0; j < N; j++) x.push_back($urandom_range(0, Q - 1));
            dft(8, 1925, 1, x, y);
            dft(8, 1213, 6721, y, back);
            check_list("model_roundtrip", back, x);
            send_frame(0, x);
            send_frame(1, y);
        end
        wait_drain();
        rnd_ready = 0;

        // reset in the middle of COMPUTE aborts the frame
        send_frame(0, imp);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 0;
        @(posedge clk);
        #1;
        reset = 1;
        @(negedge clk);
        check("post_reset_out_valid", out_valid, 0);
        check("post_reset_busy", busy, 0);
        check("post_reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        send_frame(0, imp);
        wait_drain();

        // N=4 instance
        reset4 = 1;
        for (int j = 0; j < 4; j++) begin
            in_valid4 = 1; in_data4 = W'(j + 1); in_mode4 = 0;
            guard = 0;
            @(negedge clk);
            while (!in_ready4 && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 200) fail_now("n4_in_timeout");
            @(posedge clk);
            #1;
        end
        in_valid4 = 0;
        for (int k = 0; k < 4; k++) begin
            guard = 0;
            @(negedge clk);
            while (!out_valid4 && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 200) fail_now("n4_out_timeout");
            check("n4_out_data", out_data4, lit_n4[k]);
            check("n4_out_last", out_last4, 64'(k == 3));
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
